// File: rtl/ped_walk_ctrl.sv
// Pedestrian WALK/DON'T-WALK controller slaved to the vehicle lamp bus.
// Optional PED_AUTO_RECALL_EN: every red phase serves a walk interval.
module ped_walk_ctrl #(
    parameter int WALK_T  = 8,
    parameter int CLEAR_T = 5,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [0:2]       lig,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pend,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             flash, flash_n;
    logic             req_n, fault_n;
    logic             s1, s2, s3;
    logic [0:2]       lig_q;
    logic             btn_evt, red_rise, is_red, illegal, go;

    assign btn_evt  = s2 & ~s3;
    assign is_red   = (lig == RED);
    assign red_rise = is_red && (lig_q != RED);
    assign illegal  = !(is_red || lig == GREEN || lig == YELLOW);

    always_comb begin
        state_n = state;
        timer_n = timer;
        flash_n = flash;
        req_n   = req_pend | btn_evt;
        fault_n = fault | illegal;
`ifdef PED_AUTO_RECALL_EN
        go = red_rise;
`else
        go = red_rise && (req_pend || btn_evt);
`endif
        unique case (state)
            IDLE: begin
                if (go && !fault_n) begin
                    state_n = WALK;
                    timer_n = CNT_W'(WALK_T);
                    req_n   = 1'b0;
                end
            end
            WALK: begin
                // Already being served: a press now is not a new request.
                req_n = req_pend;
                if (!is_red) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (tick && timer == CNT_W'(1)) begin
                    state_n = CLEAR;
                    timer_n = CNT_W'(CLEAR_T);
                    flash_n = 1'b1;
                end else if (tick && timer != '0) begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            CLEAR: begin
                if (!is_red) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (tick) begin
                    flash_n = ~flash;
                    if (timer == CNT_W'(1)) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end else if (timer != '0) begin
                        timer_n = timer - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            flash     <= 1'b1;
            req_pend  <= 1'b0;
            fault     <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            lig_q     <= '0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            flash     <= flash_n;
            req_pend  <= req_n;
            fault     <= fault_n;
            s1        <= btn;
            s2        <= s1;
            s3        <= s2;
            lig_q     <= lig;
            walk      <= (state_n == WALK);
            dont_walk <= (state_n == IDLE) ? 1'b1 :
                         (state_n == CLEAR) ? flash_n : 1'b0;
            countdown <= (state_n == CLEAR) ? timer_n : '0;
        end
    end

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Directed bench for ped_walk_ctrl with hand-computed expectations.
module tb_ped_walk_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [0:2] lig;
    logic       btn = 1'b0;
    logic       walk, dont_walk, req_pend, fault;
    logic [3:0] countdown;

    int checks = 0;
    int failures = 0;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;
    localparam logic [0:2] BAD    = 3'b110;

    ped_walk_ctrl #(.WALK_T(8), .CLEAR_T(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .lig(lig), .btn(btn),
        .walk(walk), .dont_walk(dont_walk), .countdown(countdown),
        .req_pend(req_pend), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic press();
        btn = 1'b1;
        cyc(2);
        btn = 1'b0;
        cyc(2);
    endtask

    int exp_cd[5] = '{4, 3, 2, 1, 0};
    int exp_dw[5] = '{0, 1, 0, 1, 1};

    initial begin
        lig = GREEN;
        #12;
        chk("rst_walk", walk, 0);
        chk("rst_dw", dont_walk, 1);
        chk("rst_cd", countdown, 0);
        chk("rst_req", req_pend, 0);
        chk("rst_fault", fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // no request: green -> yellow -> red
        lig = YELLOW; cyc(2);
        lig = RED;    cyc(2);
`ifdef PED_AUTO_RECALL_EN
        chk("norq_walk", walk, 1);
`else
        chk("norq_walk", walk, 0);
`endif
        lig = GREEN; cyc(2);
        chk("norq_idle", walk, 0);

        // request latency: set on third clk
        btn = 1'b1;
        cyc(2);
        chk("btn_lat2", req_pend, 0);
        cyc(1);
        chk("btn_lat3", req_pend, 1);
        btn = 1'b0;
        cyc(2);
        lig = RED;
        cyc(1);
        chk("walk_on", walk, 1);
        chk("walk_dw", dont_walk, 0);
        chk("walk_req", req_pend, 0);
        repeat (7) do_tick();
        chk("walk_t7", walk, 1);
        chk("walk_t7_cd", countdown, 0);
        do_tick();
        chk("clr_walk", walk, 0);
        chk("clr_cd5", countdown, 5);
        chk("clr_dw5", dont_walk, 1);
        for (int i = 0; i < 5; i++) begin
            do_tick();
            chk($sformatf("clr_cd%0d", i), countdown, exp_cd[i]);
            chk($sformatf("clr_dw%0d", i), dont_walk, exp_dw[i]);
            if (i == 0) begin
                press();
                chk("clr_req", req_pend, 1);
                chk("clr_hold", countdown, 4);
            end
        end
        chk("end_walk", walk, 0);
        chk("end_req", req_pend, 1);

        // pending request served next red phase; abort at tick 3
        lig = GREEN; cyc(2);
        lig = RED;   cyc(1);
        chk("rq2_walk", walk, 1);
        chk("rq2_req", req_pend, 0);
        repeat (2) do_tick();
        tick = 1'b1;
        lig = GREEN;
        @(negedge clk);
        tick = 1'b0;
        chk("abort_walk", walk, 0);
        chk("abort_dw", dont_walk, 1);
        chk("abort_cd", countdown, 0);
        cyc(2);

        // illegal lamp code: sticky fault
        lig = BAD; cyc(1);
        lig = GREEN; cyc(1);
        chk("fault_set", fault, 1);
        press();
        cyc(1);
        lig = RED; cyc(3);
        chk("fault_walk", walk, 0);
        chk("fault_dw", dont_walk, 1);
        chk("fault_req", req_pend, 1);
        chk("fault_stick", fault, 1);

        // async reset mid-WALK
        lig = GREEN;
        rst_n = 1'b0; #1;
        chk("frst_fault", fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        press();
        cyc(1);
        lig = RED; cyc(1);
        chk("w3_walk", walk, 1);
        do_tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_walk", walk, 0);
        chk("arst_dw", dont_walk, 1);
        chk("arst_cd", countdown, 0);
        chk("arst_req", req_pend, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
